// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - Default 800x480 panel timing and the RGB pixel type for the video output stage
package vga_pkg;

  localparam int DEF_HDISP  = 800;
  localparam int DEF_HFP    = 40;
  localparam int DEF_HPULSE = 48;
  localparam int DEF_HBP    = 40;
  localparam int DEF_VDISP  = 480;
  localparam int DEF_VFP    = 13;
  localparam int DEF_VPULSE = 3;
  localparam int DEF_VBP    = 29;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - Free-running HS/VS/BLANK timing with show-ahead FIFO pixel pop and registered RGB
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HDISP  = DEF_HDISP,
  parameter int HFP    = DEF_HFP,
  parameter int HPULSE = DEF_HPULSE,
  parameter int HBP    = DEF_HBP,
  parameter int VDISP  = DEF_VDISP,
  parameter int VFP    = DEF_VFP,
  parameter int VPULSE = DEF_VPULSE,
  parameter int VBP    = DEF_VBP
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [23:0] fifo_rdata,
  input  logic        fifo_rempty,
  output logic        fifo_read,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start,
  output logic        underflow
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  rgb_t          r_rgb;
  logic          r_frame_start;
  logic          r_underflow;

  logic [31:0]   w_h;
  logic [31:0]   w_v;
  logic          w_active;
  logic          w_hsync;
  logic          w_vsync;
  logic          w_read;

  // Decode in 32 bits so boundaries equal to a power of two cannot alias.
  assign w_h      = 32'(r_h_cnt);
  assign w_v      = 32'(r_v_cnt);
  assign w_active = (w_h < HDISP) && (w_v < VDISP);
  assign w_hsync  = (w_h >= HDISP + HFP) && (w_h < HDISP + HFP + HPULSE);
  assign w_vsync  = (w_v >= VDISP + VFP) && (w_v < VDISP + VFP + VPULSE);
  assign w_read   = w_active && !fifo_rempty && !pixel_rst;
  assign fifo_read = w_read;

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  // Starved active pixels go out black; the counters keep running regardless.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_hs          <= !w_hsync;
      r_vs          <= !w_vsync;
      r_blank       <= w_active;
      r_rgb         <= w_read ? rgb_t'(fifo_rdata) : '0;
      r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
      r_underflow   <= r_underflow || (w_active && fifo_rempty);
    end
  end

  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank   = r_blank;
  assign vga_r       = r_rgb.r;
  assign vga_g       = r_rgb.g;
  assign vga_b       = r_rgb.b;
  assign frame_start = r_frame_start;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - Bench for vga_timing_gen on a reduced 8x6 raster against a frame-position model
module tb_vga_timing_gen;

  localparam int HDISP = 4, HFP = 1, HPULSE = 2, HBP = 1;
  localparam int VDISP = 3, VFP = 1, VPULSE = 1, VBP = 1;
  localparam int HTOT = 8;
  localparam int VTOT = 6;
  localparam int FRAME = HTOT * VTOT;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic [23:0] fifo_rdata = '0;
  logic        fifo_rempty = 1'b0;
  logic        fifo_read;
  logic        vga_hs, vga_vs, vga_blank;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        frame_start, underflow;

  int          checks = 0;
  int          errors = 0;
  int          pos = 0;
  logic [23:0] next_data = 24'h000001;
  logic        model_uf = 1'b0;
  int          dut_pops;
  int          model_pops;

  vga_timing_gen #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .pixel_clk  (pixel_clk),
    .pixel_rst  (pixel_rst),
    .fifo_rdata (fifo_rdata),
    .fifo_rempty(fifo_rempty),
    .fifo_read  (fifo_read),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_blank  (vga_blank),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .frame_start(frame_start),
    .underflow  (underflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s pos=%0d observed=%0h expected=%0h", tag, pos, obs, exp);
    end
  endtask

  // One pixel clock: pos is the raster position (h = pos % HTOT, v = pos / HTOT)
  // counted from the last reset release; outputs follow from plain timing rules.
  task automatic cycle(input logic rst, input logic empty);
    int   h, v;
    logic act, exp_read;
    logic e_hs, e_vs, e_blank, e_fs, e_uf;
    logic [23:0] e_rgb;
    h = pos % HTOT;
    v = pos / HTOT;
    pixel_rst   = rst;
    fifo_rempty = empty;
    fifo_rdata  = next_data;
    #1;
    act      = (h < HDISP) && (v < VDISP);
    exp_read = !rst && act && !empty;
    check("fifo_read", 32'(fifo_read), 32'(exp_read));
    if (fifo_read) dut_pops++;
    if (rst) begin
      e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_rgb = '0; e_fs = 1'b0; e_uf = 1'b0;
    end else begin
      e_hs    = !(h >= HDISP + HFP && h < HDISP + HFP + HPULSE);
      e_vs    = !(v >= VDISP + VFP && v < VDISP + VFP + VPULSE);
      e_blank = act;
      e_rgb   = exp_read ? next_data : 24'h0;
      e_fs    = (pos == 0);
      e_uf    = model_uf || (act && empty);
    end
    if (exp_read) begin
      model_pops++;
      next_data = next_data + 24'h1;
    end
    model_uf = e_uf;
    pos = rst ? 0 : (pos + 1) % FRAME;
    @(posedge pixel_clk);
    #1;
    check("vga_hs", 32'(vga_hs), 32'(e_hs));
    check("vga_vs", 32'(vga_vs), 32'(e_vs));
    check("vga_blank", 32'(vga_blank), 32'(e_blank));
    check("rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, e_rgb});
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("underflow", 32'(underflow), 32'(e_uf));
    @(negedge pixel_clk);
  endtask

  // mode 0: FIFO never empty; 1: empty only at (h=2,v=0); 2: random empties
  task automatic run_frame(input int mode);
    logic e;
    dut_pops = 0;
    model_pops = 0;
    for (int i = 0; i < FRAME; i++) begin
      case (mode)
        0:       e = 1'b0;
        1:       e = (pos % HTOT == 2) && (pos / HTOT == 0);
        default: e = ($urandom_range(0, 3) == 0);
      endcase
      cycle(1'b0, e);
    end
    case (mode)
      0:       check("pops_full_frame", 32'(dut_pops), 32'(HDISP * VDISP));
      1:       check("pops_one_starved", 32'(dut_pops), 32'(HDISP * VDISP - 1));
      default: check("pops_random", 32'(dut_pops), 32'(model_pops));
    endcase
  endtask

  initial begin
    @(negedge pixel_clk);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    run_frame(0);
    run_frame(0);
    run_frame(1);
    run_frame(0);
    for (int i = 0; i < 3; i++) run_frame(2);
    cycle(1'b1, 1'b0);
    run_frame(0);
    while (pos != 2 * HTOT + 6) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check("pos_after_reset", 32'(pos), 32'(0));
    run_frame(2);
    run_frame(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
